// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the fetch PC and turns stall/redirect inputs into one prioritized fetch action per negedge.
module fetch_sequencer #(
  parameter int P_PC_WIDTH = 16,
  parameter logic [P_PC_WIDTH-1:0] P_RESET_PC = '0,
  parameter int P_BR_BUBBLES = 2,
  parameter int P_CNT_WIDTH = 16
) (
  input  logic                   I_CLOCK,
  input  logic                   I_LOCK,
  input  logic [P_PC_WIDTH-1:0]  I_BranchPC,
  input  logic                   I_BranchAddrSelect,
  input  logic                   I_BranchStallSignal,
  input  logic                   I_DepStallSignal,
  input  logic                   I_GPUStallSignal,
  output logic                   O_LOCK,
  output logic [P_PC_WIDTH-1:0]  O_FetchPC,
  output logic                   O_Hold,
  output logic                   O_InsertNOP,
  output logic                   O_FE_Valid,
  output logic [1:0]             O_State,
  output logic [P_CNT_WIDTH-1:0] O_BrStallCnt,
  output logic [P_CNT_WIDTH-1:0] O_DepStallCnt
);
  typedef enum logic [1:0] {RUN, HOLD, BR_WAIT, BR_DRAIN} state_t;
  state_t state, state_n;
  logic [P_PC_WIDTH-1:0] pc, pc_n;
  logic [2:0] drain, drain_n;
  logic [P_CNT_WIDTH-1:0] br_cnt, dep_cnt;
  always_comb begin
    state_n = state;
    pc_n = pc;
    drain_n = drain;
    if (I_BranchAddrSelect) begin
      pc_n = I_BranchPC & ~P_PC_WIDTH'(3);
      state_n = RUN;
      drain_n = '0;
    end else if (I_GPUStallSignal | I_DepStallSignal)
      state_n = (state == RUN || state == HOLD) ? HOLD : state;
    else if (I_BranchStallSignal)
      state_n = BR_WAIT;
    else
      case (state)
        RUN: pc_n = pc + P_PC_WIDTH'(4);
        HOLD: state_n = RUN;
        BR_WAIT: begin
          state_n = BR_DRAIN;
          drain_n = 3'(P_BR_BUBBLES);
        end
        default: begin
          drain_n = drain - 3'd1;
          state_n = (drain == 3'd1) ? RUN : BR_DRAIN;
        end
      endcase
  end
  always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
    if (!I_LOCK) begin
      state <= RUN;
      pc <= P_RESET_PC;
      drain <= '0;
      br_cnt <= '0;
      dep_cnt <= '0;
      O_LOCK <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      drain <= drain_n;
      O_LOCK <= 1'b1;
      // counters saturate at all-ones rather than wrapping
      if ((state_n == BR_WAIT || state_n == BR_DRAIN) && !(&br_cnt))
        br_cnt <= br_cnt + P_CNT_WIDTH'(1);
      if (state_n == HOLD && !(&dep_cnt))
        dep_cnt <= dep_cnt + P_CNT_WIDTH'(1);
    end
  end
  assign O_FetchPC = pc;
  assign O_State = state;
  assign O_Hold = (state == HOLD) || (state == BR_WAIT);
  assign O_InsertNOP = (state == BR_DRAIN);
  assign O_FE_Valid = (state == RUN) || (state == HOLD);
  assign O_BrStallCnt = br_cnt;
  assign O_DepStallCnt = dep_cnt;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vector table, corner sequences and a randomized run against a behavioural model.
module tb_fetch_sequencer;
  localparam int PW = 16;
  localparam int CW = 8;
  localparam int BUB = 2;
  logic clk = 1'b0;
  logic lock, bsel, brs, dep, gpu, o_lock, hold, nop, valid;
  logic [PW-1:0] bpc, pc;
  logic [1:0] st;
  logic [CW-1:0] brc, depc;
  int checks = 0;
  int failures = 0;
  fetch_sequencer #(.P_PC_WIDTH(PW), .P_RESET_PC(16'h0000), .P_BR_BUBBLES(BUB), .P_CNT_WIDTH(CW)) dut (
    .I_CLOCK(clk), .I_LOCK(lock), .I_BranchPC(bpc), .I_BranchAddrSelect(bsel),
    .I_BranchStallSignal(brs), .I_DepStallSignal(dep), .I_GPUStallSignal(gpu),
    .O_LOCK(o_lock), .O_FetchPC(pc), .O_Hold(hold), .O_InsertNOP(nop), .O_FE_Valid(valid),
    .O_State(st), .O_BrStallCnt(brc), .O_DepStallCnt(depc)
  );
  always #5 clk = ~clk;
  int m_st, m_left, m_br, m_dep;
  logic [PW-1:0] m_pc;
  logic m_lock;
  task automatic model_reset();
    m_st = 0; m_pc = '0; m_left = 0; m_br = 0; m_dep = 0; m_lock = 1'b0;
  endtask
  task automatic model_step(input logic s, input logic [PW-1:0] t, input logic b, input logic d, input logic g);
    if (s) begin
      m_pc = {t[PW-1:2], 2'b00}; m_st = 0; m_left = 0;
    end else if (d || g) begin
      if (m_st <= 1) m_st = 1;
    end else if (b) m_st = 2;
    else if (m_st == 0) m_pc = m_pc + 16'd4;
    else if (m_st == 1) m_st = 0;
    else if (m_st == 2) begin
      m_st = 3; m_left = BUB;
    end else begin
      m_left--;
      if (m_left == 0) m_st = 0;
    end
    if (m_st == 1 && m_dep < (1 << CW) - 1) m_dep++;
    if (m_st >= 2 && m_br < (1 << CW) - 1) m_br++;
    m_lock = 1'b1;
  endtask
  function automatic logic [63:0] pack(int s, logic [PW-1:0] p, int b, int d, logic l);
    return {26'd0, 2'(s), p, s == 1 || s == 2, s == 3, s < 2, CW'(b), CW'(d), l};
  endfunction
  function automatic logic [63:0] actual();
    return {26'd0, st, pc, hold, nop, valid, brc, depc, o_lock};
  endfunction
  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic step(input logic s, input logic [PW-1:0] t, input logic b, input logic d, input logic g);
    bsel = s; bpc = t; brs = b; dep = d; gpu = g;
    @(negedge clk);
    if (lock) model_step(s, t, b, d, g);
    #1;
  endtask
  typedef struct {
    logic s; logic [PW-1:0] t; logic b; logic d; logic g;
    int e_st; logic [PW-1:0] e_pc; int e_br; int e_dep;
  } vec_t;
  vec_t v[24];
  initial begin
    lock = 1'b0; bsel = 0; bpc = '0; brs = 0; dep = 0; gpu = 0;
    model_reset();
    v[0]  = '{0, 16'h0, 0, 0, 0, 0, 16'h4, 0, 0};
    v[1]  = '{0, 16'h0, 0, 0, 0, 0, 16'h8, 0, 0};
    v[2]  = '{0, 16'h0, 0, 1, 0, 1, 16'h8, 0, 1};
    v[3]  = '{0, 16'h0, 0, 1, 0, 1, 16'h8, 0, 2};
    v[4]  = '{0, 16'h0, 0, 1, 0, 1, 16'h8, 0, 3};
    v[5]  = '{0, 16'h0, 0, 0, 0, 0, 16'h8, 0, 3};
    v[6]  = '{0, 16'h0, 0, 0, 0, 0, 16'hC, 0, 3};
    v[7]  = '{0, 16'h0, 1, 0, 0, 2, 16'hC, 1, 3};
    v[8]  = '{0, 16'h0, 1, 0, 0, 2, 16'hC, 2, 3};
    v[9]  = '{0, 16'h0, 0, 0, 0, 3, 16'hC, 3, 3};
    v[10] = '{0, 16'h0, 0, 0, 0, 3, 16'hC, 4, 3};
    v[11] = '{0, 16'h0, 0, 0, 0, 0, 16'hC, 4, 3};
    v[12] = '{0, 16'h0, 0, 0, 0, 0, 16'h10, 4, 3};
    v[13] = '{0, 16'h0, 1, 0, 0, 2, 16'h10, 5, 3};
    v[14] = '{0, 16'h0, 0, 0, 0, 3, 16'h10, 6, 3};
    v[15] = '{1, 16'h42, 0, 0, 0, 0, 16'h40, 6, 3};
    v[16] = '{0, 16'h0, 0, 1, 0, 1, 16'h40, 6, 4};
    v[17] = '{1, 16'h20, 0, 0, 1, 0, 16'h20, 6, 4};
    v[18] = '{0, 16'h0, 1, 0, 0, 2, 16'h20, 7, 4};
    v[19] = '{0, 16'h0, 0, 0, 0, 3, 16'h20, 8, 4};
    v[20] = '{0, 16'h0, 0, 0, 1, 3, 16'h20, 9, 4};
    v[21] = '{0, 16'h0, 0, 0, 1, 3, 16'h20, 10, 4};
    v[22] = '{0, 16'h0, 0, 0, 0, 3, 16'h20, 11, 4};
    v[23] = '{0, 16'h0, 0, 0, 0, 0, 16'h20, 11, 4};
    #3 cmp("reset", actual(), pack(0, 16'h0, 0, 0, 0));
    @(posedge clk); #1 lock = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step(v[i].s, v[i].t, v[i].b, v[i].d, v[i].g);
      cmp($sformatf("vec%0d", i), actual(), pack(v[i].e_st, v[i].e_pc, v[i].e_br, v[i].e_dep, 1'b1));
    end
    step(1, 16'hFFFE, 0, 0, 0);
    cmp("redirect_fffc", 64'(pc), 64'h FFFC);
    step(0, 16'h0, 0, 0, 0);
    cmp("pc_wrap", 64'(pc), 64'h0000);
    for (int i = 0; i < 300; i++) step(0, 16'h0, 0, 1, 0);
    cmp("dep_sat", 64'(depc), 64'hFF);
    step(0, 16'h0, 0, 1, 0);
    step(0, 16'h0, 0, 0, 1);
    cmp("dep_sat_hold", {56'd0, depc}, 64'hFF);
    cmp("dep_sat_state", 64'(st), 64'd1);
    step(0, 16'h0, 1, 0, 0);
    cmp("br_wait_before_reset", 64'(st), 64'd2);
    @(posedge clk); #1 lock = 1'b0;
    model_reset();
    #1 cmp("async_reset", actual(), pack(0, 16'h0, 0, 0, 0));
    @(posedge clk); #1 lock = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        lock = 1'b0;
        model_reset();
        #1 cmp("rand_async_reset", actual(), pack(m_st, m_pc, m_br, m_dep, m_lock));
        lock = 1'b1;
      end
      step($urandom_range(0, 15) == 0, 16'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
      cmp($sformatf("rand%0d", i), actual(), pack(m_st, m_pc, m_br, m_dep, m_lock));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control sequencer for the instruction fetch stage of the GPU pipeline. It owns the fetch program counter and turns the decode/memory/GPU stall and redirect signals into one prioritized fetch action per cycle: advance, hold, wait on a branch, drain bubbles, or redirect. It sits between the decode/memory/GPU stages and the instruction-memory read port. The fetch latch consumes its hold, NOP and valid outputs directly.

## Interface
- P_PC_WIDTH, 16: PC width.
- P_RESET_PC, 16'h0000: PC loaded during reset.
- P_BR_BUBBLES, 2: NOP cycles emitted after the branch stall drops; legal range 1..7.
- P_CNT_WIDTH, 16: width of the stall performance counters.

- I_CLOCK  in  1  single clock; all state updates on negedge.
- I_LOCK  in  1  reset, asynchronous, active-low (0 = held in reset).
- I_BranchPC  in  P_PC_WIDTH  branch target from the memory stage.
- I_BranchAddrSelect  in  1  branch target valid this cycle (redirect).
- I_BranchStallSignal  in  1  branch in decode, outcome unresolved.
- I_DepStallSignal  in  1  register dependency stall from decode.
- I_GPUStallSignal  in  1  GPU-stage stall.
- O_LOCK  out  1  registered copy of I_LOCK for downstream stages.
- O_FetchPC  out  P_PC_WIDTH  address presented to instruction memory.
- O_Hold  out  1  fetch latch keeps its current PC/IR.
- O_InsertNOP  out  1  fetch latch loads IR = 32'hFF000000.
- O_FE_Valid  out  1  fetch output valid.
- O_State  out  2  current state encoding.
- O_BrStallCnt  out  P_CNT_WIDTH  saturating count of branch-stall cycles.
- O_DepStallCnt  out  P_CNT_WIDTH  saturating count of dep/GPU-hold cycles.

## Operation
- States: RUN=0, HOLD=1, BR_WAIT=2, BR_DRAIN=3. Outputs are Moore-decoded from the state only.
  - RUN: Hold=0, NOP=0, Valid=1.
  - HOLD: Hold=1, NOP=0, Valid=1.
  - BR_WAIT: Hold=1, NOP=0, Valid=0.
  - BR_DRAIN: Hold=0, NOP=1, Valid=0.
- On each negedge, evaluate in priority order (first match wins):
  1. I_BranchAddrSelect=1, any state: PC <= {I_BranchPC[W-1:2],2'b00}; go to RUN; clear the drain counter.
  2. I_GPUStallSignal|I_DepStallSignal=1:
     - RUN or HOLD: go to HOLD; PC unchanged.
     - BR_WAIT or BR_DRAIN: stay in the state; freeze the drain counter; PC unchanged.
  3. I_BranchStallSignal=1:
     - RUN, HOLD or BR_DRAIN: go to BR_WAIT; PC unchanged.
     - BR_WAIT: stay.
  4. Otherwise:
     - RUN: PC <= PC+4.
     - HOLD: go to RUN; PC unchanged. Increments resume on the next edge.
     - BR_WAIT: go to BR_DRAIN; drain counter <= P_BR_BUBBLES.
     - BR_DRAIN: decrement the counter. When the counter is 1, go to RUN. This is the not-taken fall-through; PC is unchanged and already points past the branch.
- PC arithmetic is modulo 2^P_PC_WIDTH: FFFC+4 wraps to 0000.
- O_BrStallCnt increments on each edge that leaves the state in BR_WAIT or BR_DRAIN. O_DepStallCnt increments on each edge that leaves the state in HOLD. Both saturate at all-ones and never wrap.
- O_LOCK <= I_LOCK on each negedge. It clears asynchronously with reset.

## Timing
- Reset (I_LOCK=0, asynchronous) forces:
  - state RUN, O_FetchPC=P_RESET_PC;
  - O_Hold=0, O_InsertNOP=0, O_FE_Valid=1, O_State=0;
  - both counters 0, drain counter 0, O_LOCK=0.
- Reset asserted mid-branch or mid-drain abandons the sequence immediately.
- First PC increment happens on the first negedge with I_LOCK=1. O_LOCK rises on that same edge.
- Latency is one edge for every input. An input sampled at negedge N is reflected in the state, outputs and PC right after edge N.
- Redirect takes effect in one edge from any state and overrides a simultaneous stall.
- Minimum branch penalty: one BR_WAIT cycle, then P_BR_BUBBLES NOP cycles. A redirect cuts the sequence short.
- A branch stall re-asserted during BR_DRAIN returns to BR_WAIT. The counter is reloaded on the next exit from BR_WAIT.

## Test plan
- Reset release, no stalls, 5 edges: O_FetchPC 0,4,8,C,10; Valid=1, Hold=0 throughout. With PC=FFFC, the next edge gives 0000.
- DepStall high for 3 edges at PC=8: state HOLD, Hold=1, PC stays 8, O_DepStallCnt=3. After the stall drops: RUN with PC=8, then C.
- BranchStall high for 2 edges, then low, no redirect, P_BR_BUBBLES=2: BR_WAIT ×2 (Valid=0), BR_DRAIN ×2 (NOP=1), then RUN with PC unchanged. O_BrStallCnt=4.
- Redirect in the first BR_DRAIN cycle with I_BranchPC=0x0042: next edge RUN, O_FetchPC=0x0040, NOP=0.
- Simultaneous I_BranchAddrSelect=1 and I_GPUStallSignal=1 in HOLD with I_BranchPC=0x20: RUN, PC=0x20. With GPU stall alone during BR_DRAIN, the counter freezes for the stall cycles.
- Force O_DepStallCnt to FFFF via a long stall, then add 2 more HOLD edges: stays FFFF. Assert I_LOCK=0 in BR_WAIT: outputs return to reset values asynchronously, without waiting for a clock edge.
